fpu_sequencer: RTL and testbench

Multi-cycle issue controller for the floating-point units in the pipelined core's execute stage. It accepts one FP operation (fadd/fsub/fmul/fdiv/fsqrt, selected by the 4-bit ALU control code) and latches its operands and destination register. It holds the pipeline stalled for the unit's fixed latency, then presents the captured result for exactly one cycle. It sits between the decode/execute pipeline registers and the FP units, and feeds the hazard unit's stall/flush logic.

---
 rtl/fpu_sequencer.sv | 90 +++++++++
 tb/tb_fpu_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/fpu_sequencer.sv
// Issue controller for the multi-cycle FP units: latches one op, stalls the
// pipeline for the unit's fixed latency, then presents the result for one cycle.
module fpu_sequencer #(
    parameter int LAT_FADD  = 2,
    parameter int LAT_FMUL  = 2,
    parameter int LAT_FDIV  = 8,
    parameter int LAT_FSQRT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [4:0]  rd_in,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    input  logic        flush,
    input  logic [31:0] y_unit,
    output logic [3:0]  unit_op,
    output logic [31:0] unit_a,
    output logic [31:0] unit_b,
    output logic        stall,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  rd_out
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic [4:0]  rd_lat;
    logic        op_fp, accept;

    function automatic logic [3:0] lat_m1(input logic [3:0] o);
        case (o)
            4'b1000, 4'b1001: lat_m1 = 4'(LAT_FADD - 1);
            4'b1010:          lat_m1 = 4'(LAT_FMUL - 1);
            4'b1011:          lat_m1 = 4'(LAT_FDIV - 1);
            default:          lat_m1 = 4'(LAT_FSQRT - 1);
        endcase
    endfunction

    assign op_fp  = (op >= 4'b1000) && (op <= 4'b1100);
    assign accept = start & op_fp & ~flush & ~reset & (state != RUN);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (flush) state_nxt = IDLE;
                     else if (cnt == 4'd0) state_nxt = DONE;
            DONE:    state_nxt = accept ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Combinational stall freezes the issuing instruction in its own start cycle.
    assign stall = (state == RUN) | accept;
    assign done  = (state == DONE) & ~flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            rd_lat  <= 5'd0;
            unit_op <= 4'd0;
            unit_a  <= 32'd0;
            unit_b  <= 32'd0;
            result  <= 32'd0;
            rd_out  <= 5'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                unit_op <= op;
                unit_a  <= a_in;
                unit_b  <= b_in;
                rd_lat  <= rd_in;
                cnt     <= lat_m1(op);
            end else if (state == RUN && !flush) begin
                if (cnt != 4'd0) begin
                    cnt <= cnt - 4'd1;
                end else begin
                    result <= y_unit;
                    rd_out <= rd_lat;
                end
            end
        end
    end

endmodule

// File: tb/tb_fpu_sequencer.sv
// Randomized bench for fpu_sequencer against a cycle-timestamp reference model,
// preceded by directed scenarios for the latency, back-to-back, flush and reset cases.
module tb_fpu_sequencer;

    localparam int LAT_FADD = 2, LAT_FMUL = 2, LAT_FDIV = 8, LAT_FSQRT = 8;

    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [3:0]  op;
    logic [4:0]  rd_in;
    logic [31:0] a_in, b_in, y_unit;
    logic [3:0]  unit_op;
    logic [31:0] unit_a, unit_b, result;
    logic        stall, done;
    logic [4:0]  rd_out;

    int checks = 0, errors = 0;

    // reference model: an op accepted at cycle acc_cyc runs until acc_cyc+lat, done at +1
    bit          have_op;
    int          acc_cyc, lat, cyc;
    logic [3:0]  m_op;
    logic [31:0] m_a, m_b, e_res;
    logic [4:0]  m_rd, e_rd;

    fpu_sequencer #(.LAT_FADD(LAT_FADD), .LAT_FMUL(LAT_FMUL), .LAT_FDIV(LAT_FDIV),
                    .LAT_FSQRT(LAT_FSQRT)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .rd_in(rd_in),
        .a_in(a_in), .b_in(b_in), .flush(flush), .y_unit(y_unit),
        .unit_op(unit_op), .unit_a(unit_a), .unit_b(unit_b),
        .stall(stall), .done(done), .result(result), .rd_out(rd_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic int op_lat(input logic [3:0] o);
        if (o == 4'd8 || o == 4'd9) return LAT_FADD;
        if (o == 4'd10) return LAT_FMUL;
        if (o == 4'd11) return LAT_FDIV;
        return LAT_FSQRT;
    endfunction

    task automatic model_reset();
        have_op = 0; m_op = 0; m_a = 0; m_b = 0; m_rd = 0; e_res = 0; e_rd = 0;
    endtask

    // One clock: drive inputs after negedge, compare against the model, advance the model.
    task automatic step(input logic s, input logic [3:0] o, input logic [4:0] r,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic f, input logic rs, input logic [31:0] y);
        bit in_run, in_done, acc;
        @(negedge clk);
        start = s; op = o; rd_in = r; a_in = a; b_in = b; flush = f; reset = rs; y_unit = y;
        #1;
        in_run  = have_op && cyc > acc_cyc && cyc <= acc_cyc + lat;
        in_done = have_op && cyc == acc_cyc + lat + 1;
        acc     = s && o >= 4'd8 && o <= 4'd12 && !f && !in_run;
        if (!rs) begin
            chk("stall", 32'(stall), 32'(in_run || acc));
            chk("done", 32'(done), 32'(in_done && !f));
        end
        chk("result", result, e_res);
        chk("rd_out", 32'(rd_out), 32'(e_rd));
        chk("unit_op", 32'(unit_op), 32'(m_op));
        chk("unit_a", unit_a, m_a);
        chk("unit_b", unit_b, m_b);
        if (rs) begin
            model_reset();
        end else begin
            if (in_run && f) have_op = 0;
            if (in_done) have_op = 0;
            if (in_run && !f && cyc == acc_cyc + lat) begin
                e_res = y; e_rd = m_rd;
            end
            if (acc) begin
                have_op = 1; acc_cyc = cyc; lat = op_lat(o);
                m_op = o; m_a = a; m_b = b; m_rd = r;
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n, input logic [31:0] y);
        for (int i = 0; i < n; i++) step(0, 4'd0, 5'd0, 32'd0, 32'd0, 0, 0, y);
    endtask

    initial begin
        cyc = 0;
        model_reset();
        start = 0; op = 0; rd_in = 0; a_in = 0; b_in = 0; flush = 0; reset = 1; y_unit = 0;

        step(0, 4'd0, 5'd0, 32'd0, 32'd0, 0, 1, 32'd0);
        step(0, 4'd0, 5'd0, 32'd0, 32'd0, 0, 1, 32'd0);
        idle(1, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_rd", 32'(rd_out), 32'd0);

        // fadd 1.0 + 2.0 = 3.0
        step(1, 4'b1000, 5'd5, 32'h3F800000, 32'h40000000, 0, 0, 32'h40400000);
        chk("fadd_stall0", 32'(stall), 32'd1);
        idle(2, 32'h40400000);
        chk("fadd_stall2", 32'(stall), 32'd1);
        idle(1, 32'h40400000);
        chk("fadd_done", 32'(done), 32'd1);
        chk("fadd_stall3", 32'(stall), 32'd0);
        chk("fadd_result", result, 32'h40400000);
        chk("fadd_rd", 32'(rd_out), 32'd5);

        // fdiv then fsqrt issued in fdiv's done cycle
        step(1, 4'b1011, 5'd7, 32'h41200000, 32'h40000000, 0, 0, 32'h40A00000);
        idle(8, 32'h40A00000);
        chk("fdiv_stall8", 32'(stall), 32'd1);
        step(1, 4'b1100, 5'd9, 32'h41800000, 32'd0, 0, 0, 32'h40800000);
        chk("fdiv_done", 32'(done), 32'd1);
        chk("fdiv_rd", 32'(rd_out), 32'd7);
        chk("b2b_stall", 32'(stall), 32'd1);
        idle(8, 32'h40800000);
        chk("fsqrt_stall17", 32'(stall), 32'd1);
        idle(1, 32'h40800000);
        chk("fsqrt_done", 32'(done), 32'd1);
        chk("fsqrt_rd", 32'(rd_out), 32'd9);
        chk("fsqrt_result", result, 32'h40800000);

        // fmul flushed in cycle 1
        step(1, 4'b1010, 5'd3, 32'h40000000, 32'h40000000, 0, 0, 32'h40800000);
        step(0, 4'd0, 5'd0, 32'd0, 32'd0, 1, 0, 32'h40800000);
        idle(1, 32'hDEADBEEF);
        chk("flush_stall", 32'(stall), 32'd0);
        idle(2, 32'hDEADBEEF);
        chk("flush_result", result, 32'h40800000);

        // non-FP op codes
        step(1, 4'b0000, 5'd1, 32'd1, 32'd2, 0, 0, 32'd0);
        chk("op0_stall", 32'(stall), 32'd0);
        step(1, 4'b1111, 5'd1, 32'd1, 32'd2, 0, 0, 32'd0);
        chk("op15_stall", 32'(stall), 32'd0);
        idle(1, 32'd0);
        chk("op15_after", 32'(stall), 32'd0);

        // reset in cycle 4 of an fdiv
        step(1, 4'b1011, 5'd4, 32'h12345678, 32'h9ABCDEF0, 0, 0, 32'h55555555);
        idle(3, 32'h55555555);
        step(0, 4'd0, 5'd0, 32'd0, 32'd0, 0, 1, 32'h55555555);
        idle(1, 32'h55555555);
        chk("rst_mid_stall", 32'(stall), 32'd0);
        chk("rst_mid_unit_a", unit_a, 32'd0);
        chk("rst_mid_result", result, 32'd0);
        idle(8, 32'h55555555);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] o;
            int sel;
            sel = $urandom_range(0, 9);
            o = (sel < 7) ? 4'(8 + $urandom_range(0, 4)) : 4'($urandom);
            step($urandom_range(0, 2) != 0, o, 5'($urandom), $urandom, $urandom,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 199) == 0, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
